// File: rtl/fill_arbiter_pkg.sv
// Shared constants and types for the DRAM-cache fill write path.
package fill_arbiter_pkg;

   // Default geometry of the DRAM cache and its AXI port
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int TAG_WIDTH_DEF  = 12;
   localparam int BLANK_WIDTH_DEF = 2;
   localparam int INDEX_WIDTH_DEF = 14;
   localparam int OFFSET_WIDTH_DEF = 6;
   localparam int TAG_SIZE_DEF   = 2 + TAG_WIDTH_DEF + BLANK_WIDTH_DEF;

   // AXI ID carried on every fill write
   localparam int unsigned FILL_AXI_ID = 1;

   // AXI write response encoding for success
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic {S_IDLE, S_SEND} fill_state_e;

   // Port 0 is the tag comparator (dirty fills), port 1 the refill path (clean)
   typedef enum logic {PORT_FILL = 1'b0, PORT_REFILL = 1'b1} fill_port_e;

   // Stored tag word is {VALID, DIRTY, TAG, BLANK}; these give the flag bit positions
   function automatic int tag_valid_bit(input int tag_size);
      return tag_size - 1;
   endfunction

   function automatic int tag_dirty_bit(input int tag_size);
      return tag_size - 2;
   endfunction

endpackage

// File: rtl/fill_rr_arb.sv
// Two-way round-robin grant between the fill and refill ports.
module fill_rr_arb
   import fill_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   fill_port_e last_grant;

   // On contention hand the grant to the port that did not win last; a lone requester always wins
   always_comb begin
      grant = req;
      if (req[0] && req[1]) begin
         grant = (last_grant == PORT_FILL) ? 2'b10 : 2'b01;
      end
   end

   // Remember the winner of each accepted fill; reset favours port 0 first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= PORT_REFILL;
      end else if (advance && (grant != 2'b00)) begin
         last_grant <= grant[1] ? PORT_REFILL : PORT_FILL;
      end
   end

endmodule

// File: rtl/fill_arbiter.sv
// Write-side back end of the DRAM cache: arbitrates fill/refill, packs tag+data,
// issues single-beat AXI writes and tracks outstanding B responses.
module fill_arbiter
   import fill_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH      = AXI_DATA_WIDTH,
   parameter int ID_WIDTH        = AXI_ID_WIDTH,
   parameter int TAG_WIDTH       = TAG_WIDTH_DEF,
   parameter int BLANK_WIDTH     = BLANK_WIDTH_DEF,
   parameter int TAG_SIZE        = 2 + TAG_WIDTH + BLANK_WIDTH,
   parameter int INDEX_WIDTH     = INDEX_WIDTH_DEF,
   parameter int OFFSET_WIDTH    = OFFSET_WIDTH_DEF,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           fill_valid_i,
   output logic                           fill_ready_o,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
   input  logic                           refill_valid_i,
   output logic                           refill_ready_o,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
   output logic [ID_WIDTH-1:0]            awid_o,
   output logic [ADDR_WIDTH-1:0]          awaddr_o,
   output logic                           awvalid_o,
   input  logic                           awready_i,
   output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
   output logic                           wlast_o,
   output logic                           wvalid_o,
   input  logic                           wready_i,
   input  logic [ID_WIDTH-1:0]            bid_i,
   input  logic [1:0]                     bresp_i,
   input  logic                           bvalid_i,
   output logic                           bready_o,
   output logic                           err_o
);

   localparam int SET_LSB   = INDEX_WIDTH + OFFSET_WIDTH;
   localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
   localparam int VALID_BIT = tag_valid_bit(TAG_SIZE);
   localparam int DIRTY_BIT = tag_dirty_bit(TAG_SIZE);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   fill_state_e state, state_nxt;

   logic [1:0]                     req, grant;
   logic                           can_accept, accept;
   logic                           aw_pend, w_pend, send_done, b_hs;
   logic                           bready_q, err_q;
   logic [CNT_W-1:0]               outstanding;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] sel;
   logic [ADDR_WIDTH-1:0]          sel_addr, set_addr, awaddr_q;
   logic [DATA_WIDTH-1:0]          sel_data;
   logic [TAG_SIZE-1:0]            tag_word;
   logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_q;
   logic                           unused_ok;

   assign req = {refill_valid_i, fill_valid_i};

   fill_rr_arb u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (accept),
      .grant   (grant)
   );

   // Outputs of the FSM: readies are offered only when idle and a B slot is free
   always_comb begin
      can_accept     = (state == S_IDLE) && (outstanding < MAX_CNT);
      fill_ready_o   = can_accept & grant[0];
      refill_ready_o = can_accept & grant[1];
   end

   assign accept    = can_accept & (|req);
   assign send_done = (!aw_pend || awready_i) && (!w_pend || wready_i);
   assign b_hs      = bvalid_i & bready_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state: leave S_SEND in the cycle the last outstanding channel handshakes
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept)    state_nxt = S_SEND;
         S_SEND: if (send_done) state_nxt = S_IDLE;
         default:               state_nxt = S_IDLE;
      endcase
   end

   // Select the granted payload and build the set address and tag word
   always_comb begin
      sel      = grant[1] ? refill_data_i : fill_data_i;
      sel_addr = sel[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
      sel_data = sel[DATA_WIDTH-1:0];
      set_addr = '0;
      set_addr[SET_LSB-1:OFFSET_WIDTH] = sel_addr[SET_LSB-1:OFFSET_WIDTH];
      tag_word = '0;
      tag_word[VALID_BIT] = 1'b1;
      tag_word[DIRTY_BIT] = ~grant[1];
      tag_word[BLANK_WIDTH +: TAG_WIDTH] = sel_addr[SET_LSB +: TAG_WIDTH];
   end

   // Latch the granted fill; held stable until both channels have handshaken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awaddr_q <= '0;
         wdata_q  <= '0;
      end else if (accept) begin
         awaddr_q <= set_addr;
         wdata_q  <= {tag_word, sel_data};
      end
   end

   // AW and W valids rise together on accept and drop independently on their handshakes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_pend <= 1'b0;
         w_pend  <= 1'b0;
      end else if (accept) begin
         aw_pend <= 1'b1;
         w_pend  <= 1'b1;
      end else begin
         if (aw_pend && awready_i) aw_pend <= 1'b0;
         if (w_pend && wready_i)   w_pend  <= 1'b0;
      end
   end

   // Count writes awaiting B; a stray B at zero does not wrap the counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         case ({accept, b_hs})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // B is always accepted out of reset; error is sticky on bad response or stray B
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bready_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         bready_q <= 1'b1;
         if (b_hs && ((bresp_i != AXI_RESP_OKAY) || (outstanding == '0))) err_q <= 1'b1;
      end
   end

   assign awid_o    = ID_WIDTH'(FILL_AXI_ID);
   assign awaddr_o  = awaddr_q;
   assign awvalid_o = aw_pend;
   assign wdata_o   = wdata_q;
   assign wvalid_o  = w_pend;
   assign wlast_o   = w_pend;
   assign bready_o  = bready_q;
   assign err_o     = err_q;

   // Response ID and in-line offset bits carry no information for this path
   assign unused_ok = ^{bid_i, sel_addr[OFFSET_WIDTH-1:0]};

endmodule

// File: tb/tb_fill_arbiter.sv
// Directed bench for fill_arbiter with a queue scoreboard on the AW/W channels.
module tb_fill_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int TS = 16;
   localparam int WW = TS + DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fill_valid, fill_ready, refill_valid, refill_ready;
   logic [AW+DW-1:0] fill_data, refill_data;
   logic [IW-1:0] awid, bid;
   logic [AW-1:0] awaddr;
   logic          awvalid, awready;
   logic [WW-1:0] wdata;
   logic          wlast, wvalid, wready;
   logic [1:0]    bresp;
   logic          bvalid, bready, err;

   int checks = 0;
   int errors = 0;
   logic [AW-1:0] exp_aw[$];
   logic [WW-1:0] exp_w[$];

   fill_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TAG_WIDTH(12), .BLANK_WIDTH(2),
      .TAG_SIZE(TS), .INDEX_WIDTH(14), .OFFSET_WIDTH(6), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_data_i(fill_data),
      .refill_valid_i(refill_valid), .refill_ready_o(refill_ready), .refill_data_i(refill_data),
      .awid_o(awid), .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
      .wdata_o(wdata), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
      .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_fill(input logic [AW-1:0] ea, input logic [TS-1:0] et, input logic [DW-1:0] d);
      exp_aw.push_back(ea);
      exp_w.push_back({et, d});
   endtask

   task automatic send_b(input logic [1:0] resp);
      bvalid = 1'b1;
      bresp  = resp;
      step();
      bvalid = 1'b0;
      bresp  = 2'b00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fill_valid = 1'b0;
      refill_valid = 1'b0;
      bvalid = 1'b0;
      exp_aw.delete();
      exp_w.delete();
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Offer one fill on a port, wait (bounded) for its ready, then drop valid
   task automatic offer(input bit port, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                        input logic [AW-1:0] ea, input logic [TS-1:0] et, input string name);
      bit got = 1'b0;
      expect_fill(ea, et, d);
      if (port) begin refill_valid = 1'b1; refill_data = {addr, d}; end
      else      begin fill_valid = 1'b1;   fill_data   = {addr, d}; end
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = port ? refill_ready : fill_ready;
         step();
      end
      if (port) refill_valid = 1'b0;
      else      fill_valid = 1'b0;
      check({name, "_accepted"}, 64'(got), 64'd1);
   endtask

   // Lone port-0 fill with ready sinks: ready in N, AW/W with packed word in N+1
   task automatic run_basic(input string p);
      expect_fill(32'h0004_5640, 16'hC48C, 32'hA5A5_A5A5);
      fill_valid = 1'b1;
      fill_data  = {32'h1234_5678, 32'hA5A5_A5A5};
      @(negedge clk);
      check({p, "_fill_ready"}, 64'(fill_ready), 64'd1);
      step();
      fill_valid = 1'b0;
      @(negedge clk);
      check({p, "_awvalid"}, 64'(awvalid), 64'd1);
      check({p, "_wvalid"}, 64'(wvalid), 64'd1);
      check({p, "_wlast"}, 64'(wlast), 64'd1);
      check({p, "_awaddr"}, 64'(awaddr), 64'h0004_5640);
      check({p, "_tagword"}, 64'(wdata[WW-1:DW]), 64'hC48C);
      check({p, "_awid"}, 64'(awid), 64'd1);
      check({p, "_ready_in_send"}, 64'(fill_ready), 64'd0);
      step();
      @(negedge clk);
      check({p, "_awvalid_done"}, 64'(awvalid), 64'd0);
      step();
      send_b(2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      // Scoreboard monitor: pops on every AW/W handshake seen in the coming edge
      fork
         forever begin
            @(negedge clk);
            if (rst_n && awvalid && awready) begin
               if (exp_aw.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL aw_unexpected: got addr %0h expected no write", awaddr);
               end else check("aw_addr", 64'(awaddr), 64'(exp_aw.pop_front()));
            end
            if (rst_n && wvalid && wready) begin
               if (exp_w.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL w_unexpected: got data %0h expected no write", wdata);
               end else begin
                  check("w_data", 64'(wdata), 64'(exp_w.pop_front()));
                  check("w_last", 64'(wlast), 64'd1);
               end
            end
         end
      join_none

      fill_valid = 1'b0; refill_valid = 1'b0;
      fill_data = '0; refill_data = '0;
      awready = 1'b1; wready = 1'b1;
      bvalid = 1'b0; bresp = 2'b00; bid = '0;
      rst_n = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_fill_ready", 64'(fill_ready), 64'd0);
      check("rst_refill_ready", 64'(refill_ready), 64'd0);
      check("rst_awvalid", 64'(awvalid), 64'd0);
      check("rst_wvalid", 64'(wvalid), 64'd0);
      check("rst_bready", 64'(bready), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_awaddr", 64'(awaddr), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      @(negedge clk);
      check("bready_after_reset", 64'(bready), 64'd1);
      step();

      // Both ports at once out of reset: port 0 first, then port 1 (clean)
      expect_fill(32'h0004_5640, 16'hC48C, 32'h1111_1111);
      expect_fill(32'h0004_5640, 16'h848C, 32'h2222_2222);
      fill_valid = 1'b1;   fill_data   = {32'h1234_5678, 32'h1111_1111};
      refill_valid = 1'b1; refill_data = {32'h1234_5678, 32'h2222_2222};
      @(negedge clk);
      check("s2_fill_ready", 64'(fill_ready), 64'd1);
      check("s2_refill_wait", 64'(refill_ready), 64'd0);
      step();
      fill_valid = 1'b0;
      @(negedge clk);
      check("s2_refill_in_send", 64'(refill_ready), 64'd0);
      step();
      @(negedge clk);
      check("s2_refill_ready", 64'(refill_ready), 64'd1);
      step();
      refill_valid = 1'b0;
      step();
      send_b(2'b00);
      send_b(2'b00);

      // Single fill with ready sinks
      run_basic("s1");

      // AW stalled while W completes at once; no new accept until AW handshakes
      awready = 1'b0;
      expect_fill(32'h000C_DEC0, 16'hC2AC, 32'h3333_3333);
      expect_fill(32'h0004_5640, 16'h848C, 32'h4444_4444);
      fill_valid = 1'b1; fill_data = {32'h0ABC_DEC0, 32'h3333_3333};
      @(negedge clk);
      check("s3_fill_ready", 64'(fill_ready), 64'd1);
      step();
      fill_valid = 1'b0;
      refill_valid = 1'b1; refill_data = {32'h1234_5678, 32'h4444_4444};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("s3_awvalid_hold", 64'(awvalid), 64'd1);
         check("s3_awaddr_hold", 64'(awaddr), 64'h000C_DEC0);
         check("s3_wvalid", 64'(wvalid), (i == 0) ? 64'd1 : 64'd0);
         check("s3_refill_blocked", 64'(refill_ready), 64'd0);
         step();
      end
      awready = 1'b1;
      @(negedge clk);
      check("s3_refill_blocked_aw", 64'(refill_ready), 64'd0);
      step();
      @(negedge clk);
      check("s3_refill_ready", 64'(refill_ready), 64'd1);
      step();
      refill_valid = 1'b0;
      step();
      send_b(2'b00);
      send_b(2'b00);

      // Outstanding limit of 2: third fill waits for a B, accepted the cycle after it
      offer(1'b0, 32'hFFFF_FFFF, 32'h5555_5555, 32'h000F_FFC0, 16'hFFFC, "s4_first");
      offer(1'b0, 32'h0000_0000, 32'h6666_6666, 32'h0000_0000, 16'hC000, "s4_second");
      expect_fill(32'h0004_5640, 16'hC48C, 32'h7777_7777);
      fill_valid = 1'b1; fill_data = {32'h1234_5678, 32'h7777_7777};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("s4_third_held", 64'(fill_ready), 64'd0);
         step();
      end
      bvalid = 1'b1; bresp = 2'b00;
      @(negedge clk);
      check("s4_b_same_cycle", 64'(fill_ready), 64'd0);
      step();
      bvalid = 1'b0;
      @(negedge clk);
      check("s4_third_ready", 64'(fill_ready), 64'd1);
      step();
      fill_valid = 1'b0;
      step();
      send_b(2'b00);
      send_b(2'b00);
      @(negedge clk);
      check("s4_err_clean", 64'(err), 64'd0);
      step();

      // Error response is sticky
      offer(1'b0, 32'h1234_5678, 32'h8888_8888, 32'h0004_5640, 16'hC48C, "s5_a");
      step();
      @(negedge clk);
      check("s5_err_before", 64'(err), 64'd0);
      step();
      send_b(2'b10);
      @(negedge clk);
      check("s5_err_set", 64'(err), 64'd1);
      step();
      offer(1'b0, 32'h1234_5678, 32'h8888_9999, 32'h0004_5640, 16'hC48C, "s5_b");
      step();
      send_b(2'b00);
      @(negedge clk);
      check("s5_err_sticky", 64'(err), 64'd1);
      step();

      // Stray B at zero count flags error and leaves the counter at 0
      do_reset();
      @(negedge clk);
      check("s5_err_after_reset", 64'(err), 64'd0);
      step();
      send_b(2'b00);
      @(negedge clk);
      check("s5_err_stray_b", 64'(err), 64'd1);
      step();
      offer(1'b0, 32'h0000_0000, 32'hAAAA_0001, 32'h0000_0000, 16'hC000, "s5_c");
      offer(1'b0, 32'h0000_0000, 32'hAAAA_0002, 32'h0000_0000, 16'hC000, "s5_d");
      fill_valid = 1'b1; fill_data = {32'h0000_0000, 32'hAAAA_0003};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("s5_count_not_wrapped", 64'(fill_ready), 64'd0);
         step();
      end
      fill_valid = 1'b0;
      step();
      send_b(2'b00);
      send_b(2'b00);

      // Reset mid-send clears valids asynchronously and drops the fill
      awready = 1'b0; wready = 1'b0;
      expect_fill(32'h0004_5640, 16'hC48C, 32'h9999_9999);
      fill_valid = 1'b1; fill_data = {32'h1234_5678, 32'h9999_9999};
      @(negedge clk);
      check("s6_fill_ready", 64'(fill_ready), 64'd1);
      step();
      fill_valid = 1'b0;
      @(negedge clk);
      check("s6_awvalid_pre", 64'(awvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("s6_awvalid_async", 64'(awvalid), 64'd0);
      check("s6_wvalid_async", 64'(wvalid), 64'd0);
      check("s6_bready_async", 64'(bready), 64'd0);
      exp_aw.delete();
      exp_w.delete();
      awready = 1'b1; wready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      step();
      run_basic("s6r");

      for (int i = 0; i < 20 && (exp_aw.size() != 0 || exp_w.size() != 0); i++) step();
      check("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
      check("w_queue_drained", 64'(exp_w.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
